// File: rtl/mux_sel_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux_sel_pkg : shared types and default timing for mux_sel_ctrl      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mux_sel_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } db_state_t;

  // 10 ms debounce and 0.5 s auto period at 100 MHz
  localparam int DB_CYCLES_DEF   = 1_000_000;
  localparam int AUTO_CYCLES_DEF = 50_000_000;
  localparam int CNT_W_DEF       = 27;

endpackage
`default_nettype wire

// File: rtl/mux_sel_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux_sel_if : board inputs and mux-select outputs of mux_sel_ctrl    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface mux_sel_if;

  logic btn;
  logic auto_en;
  logic s;
  logic s_changed;
  logic btn_db;

  modport master (
    output btn,
    output auto_en,
    input  s,
    input  s_changed,
    input  btn_db
  );

  modport slave (
    input  btn,
    input  auto_en,
    output s,
    output s_changed,
    output btn_db
  );

endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_debounce : 2-flop synchronizer + 4-state debounce FSM           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module btn_debounce
  import mux_sel_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,  // >= 2
  parameter int CNT_W     = CNT_W_DEF
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic btn,
  output logic      btn_db,
  output logic      press
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync;
  logic             btn_s;
  db_state_t        state;
  logic [CNT_W-1:0] db_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], btn};
    end
  end

  assign btn_s = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE_LO;
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else begin
      case (state)
        IDLE_LO: begin
          if (btn_s) begin
            state  <= WAIT_HI;
            db_cnt <= CNT_W'(1);
          end else begin
            db_cnt <= '0;
          end
        end
        WAIT_HI: begin
          if (!btn_s) begin
            state  <= IDLE_LO;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state  <= IDLE_HI;
            db_cnt <= '0;
            btn_db <= 1'b1;
          end else begin
            db_cnt <= db_cnt + CNT_W'(1);
          end
        end
        IDLE_HI: begin
          if (!btn_s) begin
            state  <= WAIT_LO;
            db_cnt <= CNT_W'(1);
          end else begin
            db_cnt <= '0;
          end
        end
        WAIT_LO: begin
          if (btn_s) begin
            state  <= IDLE_HI;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state  <= IDLE_LO;
            db_cnt <= '0;
            btn_db <= 1'b0;
          end else begin
            db_cnt <= db_cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE_LO;
          db_cnt <= '0;
          btn_db <= 1'b0;
        end
      endcase
    end
  end

  // Decoded from the accepting transition so the select flop updates on the
  // same edge that btn_db rises.
  assign press = (state == WAIT_HI) && btn_s && (db_cnt == DB_LAST);

endmodule
`default_nettype wire

// File: rtl/mux_sel_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux_sel_ctrl : 2:1 mux select from debounced button and auto timer  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mux_sel_ctrl
  import mux_sel_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,    // >= 2
  parameter int AUTO_CYCLES = AUTO_CYCLES_DEF,  // >= 2
  parameter int CNT_W       = CNT_W_DEF         // holds max(DB,AUTO)-1
) (
  input  wire logic clk,
  input  wire logic rst_n,
  mux_sel_if.slave  sel
);

  localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_CYCLES - 1);

  logic             press;
  logic             btn_db;
  logic [1:0]       auto_sync;
  logic             auto_s;
  logic [CNT_W-1:0] per_cnt;
  logic             tick;
  logic             s_q;
  logic             s_changed_q;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_btn_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (sel.btn),
    .btn_db (btn_db),
    .press  (press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_sync <= 2'b00;
    end else begin
      auto_sync <= {auto_sync[0], sel.auto_en};
    end
  end

  assign auto_s = auto_sync[1];
  assign tick   = auto_s && (per_cnt == AUTO_LAST);

  // A press restarts the period so the next auto toggle is a full period away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
    end else if (!auto_s || press || tick) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= 1'b0;
      s_changed_q <= 1'b0;
    end else if (press || tick) begin
      s_q         <= ~s_q;
      s_changed_q <= 1'b1;
    end else begin
      s_changed_q <= 1'b0;
    end
  end

  assign sel.s         = s_q;
  assign sel.s_changed = s_changed_q;
  assign sel.btn_db    = btn_db;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mux_sel_ctrl : directed scoreboard bench, DB_CYCLES=4 AUTO=8     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_mux_sel_ctrl;

  typedef struct {
    int   cyc;
    logic s;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic exp_s = 1'b0;
  exp_t q[$];

  mux_sel_if bus ();

  mux_sel_ctrl #(
    .DB_CYCLES   (4),
    .AUTO_CYCLES (8),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sel   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_cyc(input int t);
    while (cyc < t) step(1);
  endtask

  // Each toggle is predicted as (edge number, new s value).
  task automatic expect_toggle(input int c);
    exp_t e;
    exp_s  = ~exp_s;
    e.cyc  = c;
    e.s    = exp_s;
    q.push_back(e);
  endtask

  task automatic press_clean(input int hold);
    int base;
    bus.btn = 1'b1;
    base = cyc;
    expect_toggle(base + 6);
    step(5);
    chk("press_db_before", int'(bus.btn_db), 0);
    step(1);
    chk("press_db_after", int'(bus.btn_db), 1);
    chk("press_s", int'(bus.s), int'(exp_s));
    at_cyc(base + hold);
    bus.btn = 1'b0;
    step(5);
    chk("release_db_before", int'(bus.btn_db), 1);
    step(1);
    chk("release_db_after", int'(bus.btn_db), 0);
    chk("release_s", int'(bus.s), int'(exp_s));
    step(3);
  endtask

  // Monitor: every s_changed pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.s_changed) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_s", int'(bus.s), int'(e.s));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end by 100000");
    $fatal(1);
  end

  initial begin
    int a;
    rst_n       = 1'b1;
    bus.btn     = 1'b1;
    bus.auto_en = 1'b1;

    // Asynchronous reset takes effect before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_s", int'(bus.s), 0);
    chk("rst_btn_db", int'(bus.btn_db), 0);
    chk("rst_s_changed", int'(bus.s_changed), 0);
    step(3);
    chk("rst_hold_s", int'(bus.s), 0);
    bus.auto_en = 1'b0;
    rst_n = 1'b1;
    // btn already high: debounce restarts from IDLE_LO, full 2+4 edges
    a = cyc;
    expect_toggle(a + 6);
    step(5);
    chk("post_rst_db_before", int'(bus.btn_db), 0);
    step(1);
    chk("post_rst_db_after", int'(bus.btn_db), 1);
    step(6);
    bus.btn = 1'b0;
    step(5);
    chk("post_rst_release_before", int'(bus.btn_db), 1);
    step(1);
    chk("post_rst_release_after", int'(bus.btn_db), 0);
    step(3);
    chk("post_rst_queue", q.size(), 0);

    // Bounce: 3 high, 1 low, 3 high, low
    bus.btn = 1'b1;
    for (int i = 0; i < 3; i++) begin step(1); chk("bounce_db", int'(bus.btn_db), 0); end
    bus.btn = 1'b0;
    step(1); chk("bounce_db", int'(bus.btn_db), 0);
    bus.btn = 1'b1;
    for (int i = 0; i < 3; i++) begin step(1); chk("bounce_db", int'(bus.btn_db), 0); end
    bus.btn = 1'b0;
    for (int i = 0; i < 10; i++) begin step(1); chk("bounce_db", int'(bus.btn_db), 0); end
    chk("bounce_s", int'(bus.s), int'(exp_s));

    // Two clean presses
    press_clean(12);
    press_clean(12);
    chk("two_press_queue", q.size(), 0);

    // Auto mode, then disable mid-period (counter reaches 5)
    a = cyc;
    bus.auto_en = 1'b1;
    expect_toggle(a + 10);
    expect_toggle(a + 18);
    expect_toggle(a + 26);
    at_cyc(a + 29);
    bus.auto_en = 1'b0;
    at_cyc(a + 50);
    chk("auto_queue", q.size(), 0);
    chk("auto_off_s", int'(bus.s), int'(exp_s));
    // Counter was cleared: first toggle again a full 2+8 edges out
    a = cyc;
    bus.auto_en = 1'b1;
    expect_toggle(a + 10);
    at_cyc(a + 12);
    bus.auto_en = 1'b0;
    at_cyc(a + 24);
    chk("auto_restart_queue", q.size(), 0);

    // Collision at a+18, then mid-period press at a+36 restarts the period
    a = cyc;
    bus.auto_en = 1'b1;
    expect_toggle(a + 10);
    at_cyc(a + 12);
    bus.btn = 1'b1;
    expect_toggle(a + 18);
    expect_toggle(a + 26);
    expect_toggle(a + 34);
    at_cyc(a + 20);
    bus.btn = 1'b0;
    at_cyc(a + 30);
    bus.btn = 1'b1;
    expect_toggle(a + 36);
    expect_toggle(a + 44);
    at_cyc(a + 40);
    bus.btn = 1'b0;
    at_cyc(a + 45);
    bus.auto_en = 1'b0;
    at_cyc(a + 60);
    chk("collision_queue", q.size(), 0);
    chk("collision_s", int'(bus.s), int'(exp_s));

    // Async reset while in WAIT_HI with db_cnt=2
    chk("pre_async_s", int'(bus.s), 1);
    a = cyc;
    bus.btn = 1'b1;
    at_cyc(a + 4);
    #3 rst_n = 1'b0;
    #1;
    chk("async_s", int'(bus.s), 0);
    chk("async_btn_db", int'(bus.btn_db), 0);
    chk("async_s_changed", int'(bus.s_changed), 0);
    exp_s = 1'b0;
    bus.btn = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    press_clean(12);
    chk("final_queue", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_sel_ctrl.md
Name: mux_sel_ctrl

Overview:
- Generates the select line `s` for the downstream 2:1 mux, where `s=0` passes `x` and `s=1` passes `y`.
- Sources the select from a raw board push-button and a raw mode switch.
- Synchronizes and debounces the button; each clean press toggles `s`.
- In auto mode, additionally toggles `s` at a fixed period so the mux output alternates without user input.

Parameters:
- DB_CYCLES, 1_000_000, consecutive stable synchronized-high/low cycles required to accept a button level change (10 ms at 100 MHz); must be >= 2.
- AUTO_CYCLES, 50_000_000, auto-mode toggle period in clk cycles; must be >= 2.
- CNT_W, 27, width of debounce and period counters; must hold max(DB_CYCLES, AUTO_CYCLES)-1.

Ports:
- clk  input  1  system clock; all state on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn  input  1  raw push-button, asynchronous to clk, may bounce.
- auto_en  input  1  raw slide switch, asynchronous; 1 = auto-alternate mode.
- s  output  1  registered mux select; drives the mux `s` input directly.
- s_changed  output  1  one-cycle pulse, high in the cycle after any `s` update edge.
- btn_db  output  1  debounced button level (status/LED).

Behaviour:
- Reset (rst_n=0, asynchronous, immediate): s=0, s_changed=0, btn_db=0, sync flops=0, FSM=IDLE_LO, both counters=0. Reset mid-debounce or mid-period discards all progress.
- Synchronizers: two flops each on btn and auto_en, giving btn_s and auto_s. Latency is 2 edges.
- Debounce FSM, states IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO:
  - IDLE_LO: if btn_s=1, go to WAIT_HI with db_cnt=1; else stay, db_cnt=0.
  - WAIT_HI: if btn_s=0, go to IDLE_LO with db_cnt=0. Else if db_cnt==DB_CYCLES-1, go to IDLE_HI with btn_db=1 and press=1 (internal, 1 cycle). Else db_cnt+1.
  - IDLE_HI and WAIT_LO mirror the above with polarity inverted; the release sets btn_db=0 and generates no press.
  - Net timing: btn_db rises on the edge where btn_s has been sampled 1 on DB_CYCLES consecutive edges. From a clean raw edge this is 2+DB_CYCLES edges.
- Toggle logic, with tick = auto-mode period wrap:
  - If press or tick: s <= ~s and s_changed <= 1. Otherwise s_changed <= 0.
  - press and tick in the same cycle cause exactly one toggle.
- Period counter:
  - auto_s=0: per_cnt held at 0, tick=0.
  - auto_s=1: per_cnt increments. At per_cnt==AUTO_CYCLES-1, tick=1 and per_cnt wraps to 0.
  - A press clears per_cnt to 0 in the same edge, so the next auto toggle is a full AUTO_CYCLES later.
  - First auto toggle occurs AUTO_CYCLES edges after auto_s first samples 1.
  - Deasserting auto_en mid-period: counter returns to 0 and no toggle occurs.
- Holding the button generates a single press. There is no auto-repeat.
- s is glitch-free (flop output). The mux remains purely combinational downstream.

Decomposition:
- Package mux_sel_pkg: debounce state enum (IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO) and default constants DB_CYCLES_DEF and AUTO_CYCLES_DEF.
- Sub-module btn_debounce contains the 2-flop synchronizer, FSM and db_cnt. Outputs: btn_db, press. Parameter: DB_CYCLES.
- Top level holds the auto_en synchronizer, period counter and toggle flop.

Test Plan (DB_CYCLES=4, AUTO_CYCLES=8, auto_en=0 unless stated):
- Reset: rst_n=0 for 3 cycles with btn=1, auto_en=1 -> s=0, btn_db=0, s_changed=0 immediately, without waiting for a clk edge. After release, the debounce restarts from IDLE_LO.
- Clean press: btn 0->1 just after edge 0 and held 12 cycles -> btn_db=1 and s=1 after edge 6; s_changed=1 only for the cycle after edge 6. No further toggle while held. Release -> btn_db=0 after a further 6 edges, s unchanged.
- Bounce: btn high 3 cycles, low 1, high 3, low -> btn_db stays 0, s stays 0, s_changed never asserts.
- Two clean presses separated by a clean release -> s goes 0->1->0, giving exactly two s_changed pulses.
- Auto mode: auto_en=1 held -> first s toggle 2+8 edges after auto_en rises, then every 8 edges with one s_changed pulse each. auto_en=0 at per_cnt=5 -> no toggle, per_cnt returns to 0.
- Collision and async reset: press accepted on the same edge as the auto wrap -> s toggles once, and the next auto toggle is 8 edges later. Asserting rst_n low while the FSM is in WAIT_HI with db_cnt=2 -> all outputs 0 immediately; a later clean press requires the full 2+4 edges.
